// File: rtl/warp_seq_pkg.sv
// Shared definitions for the warp sequencer: opcodes, FSM states, D-mux selects, IR field positions.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package warp_seq_pkg;

    // Opcode values held in IR[31:28]
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_BRP  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    // Core D-mux selects
    localparam logic [1:0] S2_IMM = 2'd0;
    localparam logic [1:0] S2_MEM = 2'd1;
    localparam logic [1:0] S2_ALU = 2'd2;

    // Instruction field bit positions
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 28;
    localparam int X_MSB    = 27;
    localparam int X_LSB    = 24;
    localparam int Y_MSB    = 23;
    localparam int Y_LSB    = 20;
    localparam int Z_MSB    = 19;
    localparam int Z_LSB    = 16;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;
    localparam int ALUC_MSB = 3;
    localparam int ALUC_LSB = 0;

endpackage

// File: rtl/warp_seq_decode.sv
// Instruction decoder: splits IR into core control fields and classifies the opcode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow IR continuously.
module warp_seq_decode
    import warp_seq_pkg::*;
(
    input  logic [31:0] ir,
    output logic [3:0]  x,
    output logic [3:0]  y,
    output logic [3:0]  z,
    output logic [15:0] imm,
    output logic [3:0]  aluc,
    output logic        wr,
    output logic [1:0]  wr_sel,
    output logic        is_mem,
    output logic        is_st,
    output logic        is_brp,
    output logic        is_jmp,
    output logic        is_halt,
    output logic        illegal
);

    logic [3:0] op;

    assign op   = ir[OP_MSB:OP_LSB];
    assign x    = ir[X_MSB:X_LSB];
    assign y    = ir[Y_MSB:Y_LSB];
    assign z    = ir[Z_MSB:Z_LSB];
    assign imm  = ir[IMM_MSB:IMM_LSB];
    assign aluc = ir[ALUC_MSB:ALUC_LSB];

    // Opcode classification; anything outside the defined set is illegal
    always_comb begin
        wr      = 1'b0;
        wr_sel  = S2_IMM;
        is_mem  = 1'b0;
        is_st   = 1'b0;
        is_brp  = 1'b0;
        is_jmp  = 1'b0;
        is_halt = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_NOP:  wr = 1'b0;
            OP_ALU:  begin wr = 1'b1; wr_sel = S2_ALU; end
            OP_LDI:  begin wr = 1'b1; wr_sel = S2_IMM; end
            OP_LD:   is_mem = 1'b1;
            OP_ST:   begin is_mem = 1'b1; is_st = 1'b1; end
            OP_BRP:  is_brp = 1'b1;
            OP_JMP:  is_jmp = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/warp_seq.sv
// Warp instruction sequencer: fetch, decode and drive SP-core controls; WARP_SEQ_PERF_EN adds instr_count.
// Latency: fetch >=1 cycle, EXEC exactly 1 cycle, MEM >=1 cycle until mem_ack.
// Backpressure: imem_req held until imem_valid, mem_req held until mem_ack; start ignored while busy.
module warp_seq
    import warp_seq_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_valid,
    input  logic [31:0]     imem_data,
    output logic [3:0]      x,
    output logic [3:0]      y,
    output logic [3:0]      z,
    output logic [15:0]     I,
    output logic            en,
    output logic            reg_we,
    output logic [3:0]      aluc,
    output logic [1:0]      s2,
    input  logic            P,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ack,
    output logic            busy,
    output logic            halted,
    output logic            err
`ifdef WARP_SEQ_PERF_EN
    ,
    output logic [15:0]     instr_count
`endif
);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_exec_next;
    logic [31:0]     ir;

    logic            dec_wr;
    logic [1:0]      dec_sel;
    logic            dec_mem;
    logic            dec_st;
    logic            dec_brp;
    logic            dec_jmp;
    logic            dec_halt;
    logic            dec_illegal;
    logic [15:0]     dec_imm;

    warp_seq_decode u_decode (
        .ir      (ir),
        .x       (x),
        .y       (y),
        .z       (z),
        .imm     (dec_imm),
        .aluc    (aluc),
        .wr      (dec_wr),
        .wr_sel  (dec_sel),
        .is_mem  (dec_mem),
        .is_st   (dec_st),
        .is_brp  (dec_brp),
        .is_jmp  (dec_jmp),
        .is_halt (dec_halt),
        .illegal (dec_illegal)
    );

    assign I         = dec_imm;
    assign imem_addr = pc;

    // PC leaving EXEC: jump target for JMP or taken BRP, otherwise sequential (wraps)
    always_comb begin
        pc_exec_next = pc + PC_W'(1);
        if (dec_jmp || (dec_brp && P)) begin
            pc_exec_next = PC_W'(dec_imm[7:0]);
        end
    end

    // Register-file strobe must react to mem_ack in the same cycle, so it stays combinational
    always_comb begin
        reg_we = 1'b0;
        s2     = S2_IMM;
        if (state == ST_EXEC && dec_wr) begin
            reg_we = 1'b1;
            s2     = dec_sel;
        end else if (state == ST_MEM && !dec_st && mem_ack) begin
            reg_we = 1'b1;
            s2     = S2_MEM;
        end
    end

    // Sequencer FSM with PC, IR and registered state-derived outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            pc       <= '0;
            ir       <= '0;
            imem_req <= 1'b0;
            en       <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        pc       <= '0;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                        halted   <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (imem_valid) begin
                        ir       <= imem_data;
                        state    <= ST_EXEC;
                        imem_req <= 1'b0;
                        en       <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (dec_halt || dec_illegal) begin
                        state  <= ST_HALT;
                        en     <= 1'b0;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        err    <= dec_illegal;
                    end else if (dec_mem) begin
                        state   <= ST_MEM;
                        mem_req <= 1'b1;
                        mem_we  <= dec_st;
                    end else begin
                        state    <= ST_FETCH;
                        en       <= 1'b0;
                        imem_req <= 1'b1;
                        pc       <= pc_exec_next;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        state    <= ST_FETCH;
                        en       <= 1'b0;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        imem_req <= 1'b1;
                        pc       <= pc + PC_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef WARP_SEQ_PERF_EN
    logic retire;

    // An instruction retires when EXEC hands off to FETCH/HALT, or when MEM completes
    assign retire = (state == ST_EXEC && !dec_mem) || (state == ST_MEM && mem_ack);

    // Saturating retired-instruction counter, restarted by an accepted start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_count <= '0;
        end else if ((state == ST_IDLE || state == ST_HALT) && start) begin
            instr_count <= '0;
        end else if (retire && instr_count != 16'hFFFF) begin
            instr_count <= instr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_warp_seq.sv
// Self-checking bench for warp_seq: instruction-level reference model, randomized programs and latencies.
// Latency: n/a (testbench).
// Backpressure: bench models instruction and data memories with variable response delay.
module tb_warp_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data = '0;
    logic        P = 1'b0;
    logic        mem_ack = 1'b0;

    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [3:0]  x, y, z, aluc;
    logic [15:0] I;
    logic        en, reg_we, mem_req, mem_we, busy, halted, err;
    logic [1:0]  s2;
`ifdef WARP_SEQ_PERF_EN
    logic [15:0] instr_count;
`endif

    always #5 clk = ~clk;

    warp_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .x          (x),
        .y          (y),
        .z          (z),
        .I          (I),
        .en         (en),
        .reg_we     (reg_we),
        .aluc       (aluc),
        .s2         (s2),
        .P          (P),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .halted     (halted),
        .err        (err)
`ifdef WARP_SEQ_PERF_EN
        ,
        .instr_count(instr_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Program memory and architectural model
    logic [31:0] prog [256];
    typedef enum {M_IDLE, M_FETCH, M_EXEC, M_MEM, M_HALT} mphase_t;
    mphase_t     ph = M_IDLE;
    logic [7:0]  m_pc = '0;
    logic [31:0] m_ir = '0;
    logic        m_err = 1'b0;
    int          m_cnt = 0;
    int          fwait = 0, flat = 0, mwait = 0, mlat = 0;
    int          fix_flat = -1, fix_mlat = -1, p_mode = -1;

    // Observations for hand-computed scenario checks
    logic        cap_exec_done, cap_next_done, want_next, want_ff;
    logic        cap_we;
    logic [1:0]  cap_s2;
    logic [15:0] cap_I;
    logic [3:0]  cap_x;
    logic [7:0]  cap_next, cap_ff_next;
    int          mreq_cycles, ld_we_cycles;
    logic        mwe_seen;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic clear_caps();
        cap_exec_done = 1'b0; cap_next_done = 1'b0; want_next = 1'b0; want_ff = 1'b0;
        cap_we = 1'b0; cap_s2 = '0; cap_I = '0; cap_x = '0;
        cap_next = 8'hAA; cap_ff_next = 8'hAA;
        mreq_cycles = 0; ld_we_cycles = 0; mwe_seen = 1'b0;
    endtask

    task automatic new_fetch();
        fwait = 0;
        flat  = (fix_flat >= 0) ? fix_flat : int'($urandom_range(0, 3));
    endtask

    function automatic logic [31:0] rand_instr();
        int r;
        logic [3:0] op;
        logic [27:0] rest;
        r = int'($urandom_range(0, 99));
        if      (r < 15) op = 4'h0;
        else if (r < 35) op = 4'h1;
        else if (r < 50) op = 4'h2;
        else if (r < 60) op = 4'h3;
        else if (r < 70) op = 4'h4;
        else if (r < 80) op = 4'h5;
        else if (r < 88) op = 4'h6;
        else if (r < 94) op = 4'hF;
        else             op = 4'($urandom_range(7, 14));
        rest = 28'($urandom);
        return {op, rest};
    endfunction

    // One clock: drive memories, compare DUT against the model, then advance the model
    task automatic step(input logic st);
        logic [3:0] op;
        logic [7:0] ectl;
        logic [1:0] es2;
        @(negedge clk);
        start      = st;
        P          = (p_mode < 0) ? 1'($urandom_range(0, 1)) : p_mode[0];
        imem_valid = (ph == M_FETCH) && (fwait >= flat);
        imem_data  = imem_valid ? prog[m_pc] : $urandom;
        mem_ack    = (ph == M_MEM) && (mwait >= mlat);
        #1;
        op   = m_ir[31:28];
        ectl = '0;
        es2  = 2'd0;
        // bits: imem_req, en, mem_req, mem_we, busy, halted, err, reg_we
        case (ph)
            M_FETCH: ectl = 8'b1000_1000;
            M_EXEC: begin
                ectl    = 8'b0100_1000;
                ectl[0] = (op == 4'h1) || (op == 4'h2);
                es2     = (op == 4'h1) ? 2'd2 : 2'd0;
            end
            M_MEM: begin
                ectl    = 8'b0110_1000;
                ectl[4] = (op == 4'h4);
                ectl[0] = (op == 4'h3) && mem_ack;
                es2     = 2'd1;
            end
            M_HALT: begin
                ectl    = 8'b0000_0100;
                ectl[1] = m_err;
            end
            default: ectl = '0;
        endcase
        chk("ctrl", {imem_req, en, mem_req, mem_we, busy, halted, err, reg_we}, ectl);
        if (ectl[0]) chk("s2", s2, es2);
        chk("imem_addr", imem_addr, m_pc);
        chk("fields", {x, y, z, I, aluc}, {m_ir[27:16], m_ir[15:0], m_ir[3:0]});
`ifdef WARP_SEQ_PERF_EN
        chk("instr_count", instr_count, m_cnt);
`endif
        if (ph == M_EXEC && !cap_exec_done) begin
            cap_exec_done = 1'b1;
            cap_we = reg_we; cap_s2 = s2; cap_I = I; cap_x = x;
        end
        if (ph == M_FETCH && want_next) begin
            want_next = 1'b0;
            if (!cap_next_done) begin cap_next = imem_addr; cap_next_done = 1'b1; end
            if (want_ff) begin cap_ff_next = imem_addr; want_ff = 1'b0; end
        end
        if (mem_req) mreq_cycles++;
        if (mem_req && reg_we) ld_we_cycles++;
        if (mem_we) mwe_seen = 1'b1;

        case (ph)
            M_IDLE, M_HALT: begin
                if (st) begin
                    ph = M_FETCH; m_pc = '0; m_err = 1'b0; m_cnt = 0;
                    new_fetch();
                end
            end
            M_FETCH: begin
                if (imem_valid) begin m_ir = prog[m_pc]; ph = M_EXEC; end
                else fwait++;
            end
            M_EXEC: begin
                case (op)
                    4'h3, 4'h4: begin
                        ph = M_MEM; mwait = 0;
                        mlat = (fix_mlat >= 0) ? fix_mlat : int'($urandom_range(0, 3));
                    end
                    4'hF: begin ph = M_HALT; m_cnt++; end
                    4'h0, 4'h1, 4'h2, 4'h5, 4'h6: begin
                        want_next = 1'b1;
                        want_ff   = (m_pc == 8'hFF);
                        if (op == 4'h6 || (op == 4'h5 && P)) m_pc = m_ir[7:0];
                        else m_pc = m_pc + 8'd1;
                        ph = M_FETCH; m_cnt++;
                        new_fetch();
                    end
                    default: begin ph = M_HALT; m_err = 1'b1; m_cnt++; end
                endcase
            end
            M_MEM: begin
                if (mem_ack) begin
                    m_pc = m_pc + 8'd1; ph = M_FETCH; m_cnt++;
                    new_fetch();
                end else mwait++;
            end
            default: ph = M_IDLE;
        endcase
    endtask

    // Asynchronous reset mid-cycle; every output must collapse to zero immediately
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0; start = 1'b0; imem_valid = 1'b0; mem_ack = 1'b0;
        #1;
        chk("reset_outputs", {imem_addr, imem_req, x, y, z, I, en, reg_we, aluc, s2,
                              mem_req, mem_we, busy, halted, err}, 50'd0);
        ph = M_IDLE; m_pc = '0; m_ir = '0; m_err = 1'b0; m_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_to_halt(input int maxc);
        int n;
        n = 0;
        while (ph != M_HALT && n < maxc) begin step(1'b0); n++; end
        step(1'b0);
        chk("reached_halt", halted, 1'b1);
    endtask

    task automatic fill_prog(input logic [31:0] w);
        for (int i = 0; i < 256; i++) prog[i] = w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_caps();
        fill_prog(32'hF000_0000);
        do_reset();

        // LDI x=3, fetch answered after two waiting cycles
        prog[0] = 32'h2312_00AB; fix_flat = 2; fix_mlat = 0; p_mode = 0;
        clear_caps(); step(1'b1); run_to_halt(50);
        chk("ldi_we", cap_we, 1'b1);
        chk("ldi_s2", cap_s2, 2'd0);
        chk("ldi_I", cap_I, 16'h00AB);
        chk("ldi_x", cap_x, 4'd3);
        chk("ldi_next_addr", cap_next, 8'h01);

        // LD with ack three cycles late
        fill_prog(32'hF000_0000); prog[0] = 32'h3000_0000; fix_flat = 0; fix_mlat = 3;
        clear_caps(); step(1'b1); run_to_halt(50);
        chk("ld_mem_req_cycles", mreq_cycles, 4);
        chk("ld_we_cycles", ld_we_cycles, 1);
        chk("ld_mem_we_seen", mwe_seen, 1'b0);

        // BRP taken and not taken
        fill_prog(32'hF000_0000); prog[0] = 32'h5000_0040; fix_mlat = 0; p_mode = 1;
        clear_caps(); step(1'b1); run_to_halt(50);
        chk("brp_taken_addr", cap_next, 8'h40);
        p_mode = 0;
        clear_caps(); step(1'b1); run_to_halt(50);
        chk("brp_not_taken_addr", cap_next, 8'h01);

        // JMP from 0xFF back to 0, then sequential wrap from 0xFF
        prog[0] = 32'h6000_00FF; prog[255] = 32'h6000_0000;
        clear_caps(); step(1'b1); repeat (20) step(1'b0);
        chk("jmp_ff_to_0", cap_ff_next, 8'h00);
        do_reset();
        prog[255] = 32'h0000_0000;
        clear_caps(); step(1'b1); repeat (20) step(1'b0);
        chk("pc_wrap", cap_ff_next, 8'h00);
        do_reset();

        // Illegal opcode halts with err; start clears it and refetches at 0
        fill_prog(32'hF000_0000); prog[0] = 32'h9000_0000;
        clear_caps(); step(1'b1); run_to_halt(50);
        chk("illegal_err", err, 1'b1);
        chk("illegal_no_we", cap_we, 1'b0);
        step(1'b1); step(1'b0);
        chk("restart_err_clear", err, 1'b0);
        chk("restart_addr", imem_addr, 8'h00);
        chk("restart_req", imem_req, 1'b1);
        run_to_halt(50);

        // Reset in the middle of a long fetch
        fix_flat = 20;
        step(1'b1); repeat (3) step(1'b0);
        chk("midfetch_req", imem_req, 1'b1);
        do_reset();
        step(1'b0);
        chk("after_reset_addr", imem_addr, 8'h00);
        chk("after_reset_busy", busy, 1'b0);

        // LDI, ALU, ST, HALT
        fill_prog(32'hF000_0000);
        prog[0] = 32'h2100_0005; prog[1] = 32'h1123_0003; prog[2] = 32'h4010_0000;
        fix_flat = 1; fix_mlat = 1;
        clear_caps(); step(1'b1); run_to_halt(60);
        chk("st_mem_we_seen", mwe_seen, 1'b1);
`ifdef WARP_SEQ_PERF_EN
        chk("perf_count_4", instr_count, 16'd4);
`endif

        // Randomized programs, latencies, predicates and stray starts
        fix_flat = -1; fix_mlat = -1; p_mode = -1;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 256; i++) prog[i] = rand_instr();
            clear_caps();
            step(1'b1);
            for (int c = 0; c < 250; c++) step(($urandom_range(0, 9) == 0));
            do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/warp_seq.md
WARP_SEQ -- requirements
Module: warp_seq

Interface
REQ-001 Parameter PC_W, default 8, instruction-address width.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  pulse; begins execution at PC 0 from IDLE or HALT.
REQ-005 imem_addr  output  PC_W  instruction fetch address, equal to PC.
REQ-006 imem_req  output  1  fetch request.
REQ-007 imem_valid  input  1  imem_data valid; completes the fetch.
REQ-008 imem_data  input  32  instruction word.
REQ-009 x, y, z  output  4 each  register selects to the SP cores, IR[27:24], IR[23:20], IR[19:16].
REQ-010 I  output  16  immediate, IR[15:0].
REQ-011 en  output  1  core enable.
REQ-012 reg_we  output  1  core register-file write strobe.
REQ-013 aluc  output  4  ALU operation, IR[3:0].
REQ-014 s2  output  2  D-mux select: 0 immediate, 1 data_in, 2 ALU.
REQ-015 P  input  1  core predicate flag.
REQ-016 mem_req, mem_we  output  1 each  data-memory request and write qualifier.
REQ-017 mem_ack  input  1  data-memory completion; load data is valid on the core's data_in in the same cycle.
REQ-018 busy, halted, err  output  1 each  status flags.

Function
REQ-019 Opcode IR[31:28]: 0 NOP, 1 ALU, 2 LDI, 3 LD, 4 ST, 5 BRP, 6 JMP, F HALT; all others illegal.
REQ-020 States: IDLE, FETCH, EXEC, MEM, HALT.
REQ-021 Transitions: IDLE --start--> FETCH, PC=0; HALT --start--> FETCH, PC=0, err cleared.
REQ-022 FETCH: imem_req=1 and held until imem_valid. The cycle imem_valid is sampled, IR<=imem_data and the state goes to EXEC. Minimum fetch is 1 cycle.
REQ-023 EXEC lasts exactly one cycle with en=1.
- ALU: reg_we=1, s2=2.
- LDI: reg_we=1, s2=0.
- NOP: no write.
- Each of these then goes to FETCH with PC+1.
REQ-024 LD/ST: EXEC goes to MEM. MEM holds en=1 and mem_req=1 until mem_ack; mem_we=1 for ST.
- LD: reg_we=1 and s2=1 only in the mem_ack cycle.
- Both then go to FETCH with PC+1.
REQ-025 BRP: P is sampled in EXEC. If P=1, PC<=I[7:0]; otherwise PC+1.
REQ-026 JMP: PC<=I[7:0] unconditionally.
REQ-027 HALT opcode goes to HALT with halted=1; an illegal opcode also sets err=1. The write strobes stay low in both cases.
REQ-028 PC increments modulo 2^PC_W, so 255+1 wraps to 0 at the default width.
REQ-029 reg_we, mem_req, mem_we and en are 0 in IDLE, FETCH and HALT. x, y, z, I and aluc decode from IR in every state.
REQ-030 busy=1 in FETCH, EXEC and MEM. start is ignored while busy.
REQ-031 Simultaneous start with imem_valid or mem_ack: the in-flight operation completes normally and start has no effect.

Reset
REQ-032 Reset asserted (low) in any state, including mid-fetch or mid-MEM, forces IDLE immediately.
REQ-033 Reset clears PC, IR and all status flags to 0, and drives every output to 0. Any pending memory request is dropped.

Configuration
REQ-034 WARP_SEQ_PERF_EN defined: adds output instr_count [15:0].
- Counts each instruction retired: EXEC exit to FETCH or HALT, or MEM exit on mem_ack.
- Saturates at 0xFFFF, cleared by reset and by an accepted start.
REQ-035 WARP_SEQ_PERF_EN undefined: port and counter absent; the rest of the behaviour is identical.

Structure
REQ-036 Shared package warp_seq_pkg holds:
- opcode constants;
- state encoding;
- s2 select constants (S2_IMM=0, S2_MEM=1, S2_ALU=2);
- instruction field bit positions.
REQ-037 One sub-module, warp_seq_decode: purely combinational, mapping IR to control fields and an illegal flag. FSM, PC and IR stay in warp_seq.

Verification
REQ-038 Reset low mid-FETCH with imem_req=1: all outputs 0, state IDLE, PC=0 on the next edge.
REQ-039 start, then imem_data=0x2312_00AB (LDI x=3), valid after 2 cycles: one EXEC cycle with reg_we=1, s2=0, I=0x00AB, x=3; imem_addr then becomes 1.
REQ-040 LD with mem_ack delayed 3 cycles: mem_req high 4 cycles; reg_we=1, s2=1 only in the ack cycle; mem_we=0 throughout.
REQ-041 BRP I=0x0040 with P=1: next imem_addr=0x40. Same with P=0: next imem_addr=PC+1. JMP at PC=0xFF to I=0: fetch at 0.
REQ-042 Opcode 0x9: halted=1, err=1, no strobes; a following start clears err and fetches at 0.
REQ-043 With WARP_SEQ_PERF_EN defined, program LDI, ALU, ST, HALT: instr_count=4 in HALT.
